// File: rtl/pipa_pkg.sv
// -----------------------------------------------------------------------------
// pipa_pkg
// Shared definitions for the PIPA pulse arbiter:
//   arb_state_e      - arbiter state encoding (IDLE / REQ / WAIT)
//   PIPA_NAXES_DEF   - default number of accelerometer axes
//   PIPA_CNT_W_DEF   - default width of each signed pending-pulse counter
//   sat_limit()      - magnitude at which a CNT_W-bit counter saturates
// -----------------------------------------------------------------------------
package pipa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    localparam int PIPA_NAXES_DEF = 3;
    localparam int PIPA_CNT_W_DEF = 4;

    // Symmetric limit so that +limit and -limit are both representable.
    function automatic int sat_limit(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/pipa_axis_acc.sv
// -----------------------------------------------------------------------------
// pipa_axis_acc
// One accelerometer axis: synchronises the asynchronous plus/minus pulse
// lines, turns each rising edge into a single event, and accumulates the
// events plus the arbiter's grant adjustment into a saturating signed counter.
// Optional macro: PIPA_FAIL_DETECT_EN enables the sticky BOTH/OVF flags;
// without it both flags are constant 0 and flclr_i is ignored.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           synchronous clear of everything (GOJAM)
//   pls_i, mns_i    raw asynchronous plus / minus pulse lines
//   inc_i, dec_i    grant adjustment (+1 / -1) applied this cycle
//   flclr_i         synchronous clear of the sticky flags
//   cnt_o           signed pending-pulse count
//   both_o, ovf_o   sticky simultaneous-event / saturation-loss flags
// -----------------------------------------------------------------------------
module pipa_axis_acc
    import pipa_pkg::*;
#(
    parameter int CNT_W = PIPA_CNT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    pls_i,
    input  logic                    mns_i,
    input  logic                    inc_i,
    input  logic                    dec_i,
    input  logic                    flclr_i,
    output logic signed [CNT_W-1:0] cnt_o,
    output logic                    both_o,
    output logic                    ovf_o
);

    localparam int LIM = sat_limit(CNT_W);
    localparam logic signed [CNT_W+1:0] LIM_P = (CNT_W + 2)'(LIM);
    localparam logic signed [CNT_W+1:0] LIM_N = -LIM_P;

    // [0] and [1] form the synchroniser, [2] is the previous value for edge detect
    logic [2:0] p_sync_q, m_sync_q;
    logic       ev_p_q, ev_m_q;
    logic signed [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [CNT_W+1:0] up, dn, sum;
    logic clamp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_sync_q <= '0;
            m_sync_q <= '0;
            ev_p_q   <= 1'b0;
            ev_m_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            p_sync_q <= '0;
            m_sync_q <= '0;
            ev_p_q   <= 1'b0;
            ev_m_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            p_sync_q <= {p_sync_q[1:0], pls_i};
            m_sync_q <= {m_sync_q[1:0], mns_i};
            // Registered edge event keeps the input-to-counter latency at 3 edges
            ev_p_q   <= p_sync_q[1] & ~p_sync_q[2];
            ev_m_q   <= m_sync_q[1] & ~m_sync_q[2];
            cnt_q    <= cnt_d;
        end
    end

    // Two extra bits so the unsaturated sum of up to +/-2 never wraps
    always_comb begin
        up    = {{CNT_W{1'b0}}, ev_p_q & inc_i, ev_p_q ^ inc_i};
        dn    = {{CNT_W{1'b0}}, ev_m_q & dec_i, ev_m_q ^ dec_i};
        sum   = {{2{cnt_q[CNT_W-1]}}, cnt_q} + up - dn;
        clamp = 1'b0;
        cnt_d = sum[CNT_W-1:0];
        if (sum > LIM_P) begin
            cnt_d = LIM_P[CNT_W-1:0];
            clamp = 1'b1;
        end else if (sum < LIM_N) begin
            cnt_d = LIM_N[CNT_W-1:0];
            clamp = 1'b1;
        end
    end

    assign cnt_o = cnt_q;

`ifdef PIPA_FAIL_DETECT_EN
    logic both_q, ovf_q;
    logic both_set, ovf_set;

    assign both_set = ev_p_q & ev_m_q;
    // Only a pulse event can be "lost"; a clamped grant adjustment is not flagged
    assign ovf_set  = clamp & (ev_p_q | ev_m_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            both_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (clr_i) begin
            both_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            // A same-cycle set beats the clear
            both_q <= (both_q & ~flclr_i) | both_set;
            ovf_q  <= (ovf_q & ~flclr_i) | ovf_set;
        end
    end

    assign both_o = both_q;
    assign ovf_o  = ovf_q;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = flclr_i ^ clamp;
    assign both_o = 1'b0;
    assign ovf_o  = 1'b0;
`endif

endmodule

// File: rtl/pipa_pulse_arbiter.sv
// -----------------------------------------------------------------------------
// pipa_pulse_arbiter
// Collects plus/minus accelerometer pulses on NAXES axes into per-axis signed
// counters and issues one increment/decrement request at a time to the
// counter-cycle logic, served round-robin across axes.
// Optional macro: PIPA_FAIL_DETECT_EN enables BOTH / OVF / PIPAFL.
// Ports:
//   CLOCK, rst_          clock, asynchronous active-low reset
//   PIPGp, PIPGm         asynchronous plus / minus pulse lines, one per axis
//   GOJAM                synchronous clear of counters, flags and arbiter
//   ACK                  acknowledge of the current request
//   FLCLR                synchronous clear of the sticky flags
//   PINC_REQ, MINC_REQ   increment / decrement request for axis AXIS
//   AXIS                 axis index of the current request
//   BOTH, OVF, PIPAFL    sticky fail flags and their OR
// -----------------------------------------------------------------------------
module pipa_pulse_arbiter
    import pipa_pkg::*;
#(
    parameter  int NAXES = PIPA_NAXES_DEF,
    parameter  int CNT_W = PIPA_CNT_W_DEF,
    localparam int AW    = (NAXES > 1) ? $clog2(NAXES) : 1
) (
    input  logic             CLOCK,
    input  logic             rst_,
    input  logic [NAXES-1:0] PIPGp,
    input  logic [NAXES-1:0] PIPGm,
    input  logic             GOJAM,
    input  logic             ACK,
    input  logic             FLCLR,
    output logic             PINC_REQ,
    output logic             MINC_REQ,
    output logic [AW-1:0]    AXIS,
    output logic [NAXES-1:0] BOTH,
    output logic [NAXES-1:0] OVF,
    output logic             PIPAFL
);

    logic signed [CNT_W-1:0] cnt [NAXES];
    logic [NAXES-1:0] nz, neg, ack_inc, ack_dec;

    arb_state_e    state_q, state_d;
    logic [AW-1:0] axis_q, axis_d;
    logic [AW-1:0] last_q, last_d;
    logic          minus_q, minus_d;
    logic          grant_ack;

    logic          sel_found, sel_minus;
    logic [AW-1:0] sel_idx;

    assign grant_ack = (state_q == ST_REQ) && ACK;

    generate
        for (genvar gi = 0; gi < NAXES; gi++) begin : g_axis
            // A granted MINC adds one back, a granted PINC takes one away
            assign ack_inc[gi] = grant_ack &  minus_q & (axis_q == AW'(gi));
            assign ack_dec[gi] = grant_ack & ~minus_q & (axis_q == AW'(gi));
            assign nz[gi]      = |cnt[gi];
            assign neg[gi]     = cnt[gi][CNT_W-1];

            pipa_axis_acc #(
                .CNT_W (CNT_W)
            ) u_acc (
                .clk_i   (CLOCK),
                .rst_ni  (rst_),
                .clr_i   (GOJAM),
                .pls_i   (PIPGp[gi]),
                .mns_i   (PIPGm[gi]),
                .inc_i   (ack_inc[gi]),
                .dec_i   (ack_dec[gi]),
                .flclr_i (FLCLR),
                .cnt_o   (cnt[gi]),
                .both_o  (BOTH[gi]),
                .ovf_o   (OVF[gi])
            );
        end
    endgenerate

    // Round-robin pick: first nonzero axis above last_q, else wrap from axis 0
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_minus = 1'b0;
        for (int j = 0; j < NAXES; j++) begin
            if (!sel_found && nz[j] && (j > int'(last_q))) begin
                sel_found = 1'b1;
                sel_idx   = AW'(j);
                sel_minus = neg[j];
            end
        end
        for (int j = 0; j < NAXES; j++) begin
            if (!sel_found && nz[j] && (j <= int'(last_q))) begin
                sel_found = 1'b1;
                sel_idx   = AW'(j);
                sel_minus = neg[j];
            end
        end
    end

    // State register
    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            axis_q  <= '0;
            last_q  <= AW'(NAXES - 1);
            minus_q <= 1'b0;
        end else begin
            state_q <= state_d;
            axis_q  <= axis_d;
            last_q  <= last_d;
            minus_q <= minus_d;
        end
    end

    // Next-state logic; AXIS and sign are frozen outside IDLE so a request
    // stays put even if opposing pulses zero the counter before ACK
    always_comb begin
        state_d = state_q;
        axis_d  = axis_q;
        last_d  = last_q;
        minus_d = minus_q;
        if (GOJAM) begin
            state_d = ST_IDLE;
            axis_d  = '0;
            last_d  = AW'(NAXES - 1);
            minus_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        state_d = ST_REQ;
                        axis_d  = sel_idx;
                        minus_d = sel_minus;
                    end
                end
                ST_REQ: begin
                    if (ACK) begin
                        state_d = ST_WAIT;
                        last_d  = axis_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        PINC_REQ = (state_q == ST_REQ) && !minus_q;
        MINC_REQ = (state_q == ST_REQ) &&  minus_q;
        AXIS     = axis_q;
    end

`ifdef PIPA_FAIL_DETECT_EN
    assign PIPAFL = |{BOTH, OVF};
`else
    assign PIPAFL = 1'b0;
`endif

endmodule

// File: tb/tb_pipa_pulse_arbiter.sv
module tb_pipa_pulse_arbiter;

    localparam int NAXES = 3;
    localparam int CNT_W = 4;
    localparam int AW    = 2;
    localparam int LIM   = (1 << (CNT_W - 1)) - 1;
`ifdef PIPA_FAIL_DETECT_EN
    localparam bit FD = 1'b1;
`else
    localparam bit FD = 1'b0;
`endif
    localparam logic [NAXES-1:0] FDMASK = {NAXES{FD}};

    logic             CLOCK;
    logic             rst_;
    logic [NAXES-1:0] PIPGp, PIPGm;
    logic             GOJAM, ACK, FLCLR;
    logic             PINC_REQ, MINC_REQ;
    logic [AW-1:0]    AXIS;
    logic [NAXES-1:0] BOTH, OVF;
    logic             PIPAFL;

    int n_vec = 0;
    int n_err = 0;
    int grants[$];

    pipa_pulse_arbiter #(.NAXES(NAXES), .CNT_W(CNT_W)) dut (
        .CLOCK    (CLOCK),
        .rst_     (rst_),
        .PIPGp    (PIPGp),
        .PIPGm    (PIPGm),
        .GOJAM    (GOJAM),
        .ACK      (ACK),
        .FLCLR    (FLCLR),
        .PINC_REQ (PINC_REQ),
        .MINC_REQ (MINC_REQ),
        .AXIS     (AXIS),
        .BOTH     (BOTH),
        .OVF      (OVF),
        .PIPAFL   (PIPAFL)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // ---------------- behavioural reference model ----------------
    // Pending count per axis as a plain int; input history (newest in bit 0)
    // gives an event at edge e when the line was first seen high at edge e-3.
    int       m_cnt [NAXES];
    bit [3:0] hp [NAXES];
    bit [3:0] hm [NAXES];
    int       m_phase;   // 0 idle, 1 request outstanding, 2 wait
    int       m_axis, m_last;
    bit       m_minus;
    bit [NAXES-1:0] m_both, m_ovf;

    task automatic model_clear();
        for (int i = 0; i < NAXES; i++) begin
            m_cnt[i] = 0;
            hp[i] = '0;
            hm[i] = '0;
        end
        m_phase = 0;
        m_axis  = 0;
        m_last  = NAXES - 1;
        m_minus = 1'b0;
        m_both  = '0;
        m_ovf   = '0;
    endtask

    task automatic model_edge();
        int adj [NAXES];
        int s, a;
        bit ep, em, lost, found;
        if (GOJAM) begin
            model_clear();
            return;
        end
        for (int i = 0; i < NAXES; i++) adj[i] = 0;
        if (m_phase == 1 && ACK) adj[m_axis] = m_minus ? 1 : -1;
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 1; k <= NAXES; k++) begin
                    a = (m_last + k) % NAXES;
                    if (!found && m_cnt[a] != 0) begin
                        found   = 1'b1;
                        m_phase = 1;
                        m_axis  = a;
                        m_minus = (m_cnt[a] < 0);
                    end
                end
            end
            1: if (ACK) begin
                m_last  = m_axis;
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
        for (int i = 0; i < NAXES; i++) begin
            ep   = hp[i][2] && !hp[i][3];
            em   = hm[i][2] && !hm[i][3];
            s    = m_cnt[i] + int'(ep) - int'(em) + adj[i];
            lost = 1'b0;
            if (s > LIM) begin
                s = LIM;
                lost = ep || em;
            end else if (s < -LIM) begin
                s = -LIM;
                lost = ep || em;
            end
            m_cnt[i]  = s;
            m_both[i] = (m_both[i] && !FLCLR) || (ep && em);
            m_ovf[i]  = (m_ovf[i] && !FLCLR) || lost;
            hp[i] = {hp[i][2:0], PIPGp[i]};
            hm[i] = {hm[i][2:0], PIPGm[i]};
        end
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge CLOCK);
        model_edge();
        @(negedge CLOCK);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic do_gojam();
        GOJAM = 1'b1;
        tick();
        GOJAM = 1'b0;
        tick();
    endtask

    // Acknowledge every request one cycle after it appears; record AXIS*2+MINC
    task automatic serve();
        int idle = 0;
        int guard = 0;
        grants.delete();
        while (idle < 16 && guard < 400) begin
            guard++;
            if (PINC_REQ || MINC_REQ) begin
                grants.push_back(int'(AXIS) * 2 + int'(MINC_REQ));
                tick();
                ACK = 1'b1;
                tick();
                ACK = 1'b0;
                idle = 0;
            end else begin
                tick();
                idle++;
            end
        end
        if (guard >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL serve_timeout: got %0d loops, required < 400", guard);
        end
    endtask

    function automatic int gget(input int i);
        if (i < grants.size()) return grants[i];
        return -1;
    endfunction

    function automatic int count_code(input int code);
        int n = 0;
        foreach (grants[i]) if (grants[i] == code) n++;
        return n;
    endfunction

    task automatic pulse(input logic [NAXES-1:0] p, input logic [NAXES-1:0] m, input int times);
        for (int k = 0; k < times; k++) begin
            PIPGp = p;
            PIPGm = m;
            tick();
            PIPGp = '0;
            PIPGm = '0;
            tick();
        end
    endtask

    typedef struct {
        logic [NAXES-1:0] p;
        logic [NAXES-1:0] m;
        logic             exp_pinc;
        logic             exp_minc;
        logic [AW-1:0]    exp_axis;
        logic [NAXES-1:0] exp_both;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [NAXES-1:0] flip;
        logic [NAXES-1:0] e_both, e_ovf;
        logic [AW-1:0]    e_axis;
        logic             e_pinc, e_minc, e_fl;

        tbl[0] = '{p: 3'b001, m: 3'b000, exp_pinc: 1'b1, exp_minc: 1'b0, exp_axis: 2'd0, exp_both: 3'b000};
        tbl[1] = '{p: 3'b000, m: 3'b100, exp_pinc: 1'b0, exp_minc: 1'b1, exp_axis: 2'd2, exp_both: 3'b000};
        tbl[2] = '{p: 3'b010, m: 3'b000, exp_pinc: 1'b1, exp_minc: 1'b0, exp_axis: 2'd1, exp_both: 3'b000};
        tbl[3] = '{p: 3'b010, m: 3'b010, exp_pinc: 1'b0, exp_minc: 1'b0, exp_axis: 2'd0, exp_both: 3'b010};
        tbl[4] = '{p: 3'b100, m: 3'b100, exp_pinc: 1'b0, exp_minc: 1'b0, exp_axis: 2'd0, exp_both: 3'b100};
        tbl[5] = '{p: 3'b000, m: 3'b001, exp_pinc: 1'b0, exp_minc: 1'b1, exp_axis: 2'd0, exp_both: 3'b000};

        rst_  = 1'b0;
        PIPGp = '0;
        PIPGm = '0;
        GOJAM = 1'b0;
        ACK   = 1'b0;
        FLCLR = 1'b0;
        model_clear();

        // Reset state
        @(negedge CLOCK);
        check("reset_outputs", {PINC_REQ, MINC_REQ, AXIS, BOTH, OVF, PIPAFL}, 32'd0);
        rst_ = 1'b1;
        tick();

        // Table: single events, exact latency, grant, drain
        for (int r = 0; r < 6; r++) begin
            do_gojam();
            PIPGp = tbl[r].p;
            PIPGm = tbl[r].m;
            tick();                                  // edge n: first sample
            PIPGp = '0;
            PIPGm = '0;
            tick(); tick(); tick();                  // edge n+3: counter updated
            check($sformatf("row%0d_n3_noreq", r), {PINC_REQ, MINC_REQ}, 32'd0);
            tick();                                  // edge n+4: request visible
            check($sformatf("row%0d_req", r), {PINC_REQ, MINC_REQ}, {tbl[r].exp_pinc, tbl[r].exp_minc});
            check($sformatf("row%0d_axis", r), AXIS, tbl[r].exp_axis);
            check($sformatf("row%0d_both", r), BOTH, tbl[r].exp_both & FDMASK);
            $display("row %0d: p=%b m=%b -> pinc=%b minc=%b axis=%0d both=%b",
                     r, tbl[r].p, tbl[r].m, PINC_REQ, MINC_REQ, AXIS, BOTH);
            ACK = 1'b1;                              // ignored when no request
            tick();
            ACK = 1'b0;
            check($sformatf("row%0d_wait", r), {PINC_REQ, MINC_REQ}, 32'd0);
            tick(); tick(); tick();
            check($sformatf("row%0d_drained", r), {PINC_REQ, MINC_REQ}, 32'd0);
        end

        // Three plus pulses on axis 1
        do_gojam();
        pulse(3'b010, 3'b000, 3);
        serve();
        $display("seq three_plus_ax1: %0d grants", grants.size());
        check("ax1_grants", grants.size(), 32'd3);
        check("ax1_pinc_axis1", count_code(2), 32'd3);

        // Round robin: last served axis 0, then axis 0 plus + axis 2 minus
        do_gojam();
        pulse(3'b001, 3'b000, 1);
        serve();
        check("rr_prime", gget(0), 32'd0);
        pulse(3'b001, 3'b100, 1);
        serve();
        $display("seq round_robin: grants %0d then %0d", gget(0), gget(1));
        check("rr_first_minc_ax2", gget(0), 32'd5);
        check("rr_second_pinc_ax0", gget(1), 32'd0);
        check("rr_count", grants.size(), 32'd2);

        // Saturation: ten plus pulses on axis 0, no ACK
        do_gojam();
        pulse(3'b001, 3'b000, 10);
        repeat (5) tick();
        check("sat_req", {PINC_REQ, MINC_REQ, AXIS}, {1'b1, 1'b0, 2'd0});
        check("sat_ovf", OVF, 3'b001 & FDMASK);
        check("sat_pipafl", PIPAFL, FD);
        FLCLR = 1'b1;
        tick();
        FLCLR = 1'b0;
        check("flclr_ovf", OVF, 32'd0);
        check("flclr_pipafl", PIPAFL, 32'd0);
        serve();
        $display("seq saturation: %0d grants after FLCLR", grants.size());
        check("sat_grants", grants.size(), LIM);
        check("sat_grants_ax0", count_code(0), LIM);

        // GOJAM while requesting with axis 2 at +5
        do_gojam();
        pulse(3'b100, 3'b000, 5);
        repeat (4) tick();
        check("gojam_pre", {PINC_REQ, MINC_REQ, AXIS}, {1'b1, 1'b0, 2'd2});
        GOJAM = 1'b1;
        tick();
        GOJAM = 1'b0;
        check("gojam_req_low", {PINC_REQ, MINC_REQ}, 32'd0);
        serve();
        $display("seq gojam: %0d grants after clear", grants.size());
        check("gojam_cnt_zero", grants.size(), 32'd0);

        // Asynchronous reset in WAIT
        do_gojam();
        pulse(3'b010, 3'b000, 2);
        for (int k = 0; k < 20 && !(PINC_REQ || MINC_REQ); k++) tick();
        check("rst_pre_req", {PINC_REQ, MINC_REQ, AXIS}, {1'b1, 1'b0, 2'd1});
        tick();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        rst_ = 1'b0;
        #1;
        model_clear();
        check("rst_async_outputs", {PINC_REQ, MINC_REQ, AXIS, BOTH, OVF, PIPAFL}, 32'd0);
        #2;
        rst_ = 1'b1;
        @(negedge CLOCK);
        serve();
        check("rst_lost_pulse", grants.size(), 32'd0);
        pulse(3'b000, 3'b001, 1);
        serve();
        $display("seq reset_wait: resumed with grant code %0d", gget(0));
        check("rst_resume", gget(0), 32'd1);

        // Randomised traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            flip = '0;
            for (int i = 0; i < NAXES; i++)
                flip[i] = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            PIPGp = PIPGp ^ flip;
            flip = '0;
            for (int i = 0; i < NAXES; i++)
                flip[i] = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            PIPGm = PIPGm ^ flip;
            ACK   = ($urandom_range(0, 2) == 0);
            GOJAM = ($urandom_range(0, 299) == 0);
            FLCLR = ($urandom_range(0, 49) == 0);
            tick();
            e_pinc = (m_phase == 1) && !m_minus;
            e_minc = (m_phase == 1) && m_minus;
            e_axis = m_axis[AW-1:0];
            e_both = m_both & FDMASK;
            e_ovf  = m_ovf & FDMASK;
            e_fl   = FD && ((|m_both) || (|m_ovf));
            check($sformatf("rand_c%0d", c),
                  {PINC_REQ, MINC_REQ, AXIS, BOTH, OVF, PIPAFL},
                  {e_pinc, e_minc, e_axis, e_both, e_ovf, e_fl});
        end
        $display("random phase: 3000 cycles compared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
